uart_alu_parser: RTL and testbench



---
 rtl/uart_alu_pkg.sv | 33 +++
 rtl/uart_alu_parser.sv | 182 ++++++++++++++++++
 tb/tb_uart_alu_parser.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_alu_pkg.sv
// Shared types and constants for the UART ALU packet path.
// The parser's optional idle-timeout is enabled with `define PARSER_TIMEOUT_EN.
package uart_alu_pkg;

  localparam logic [7:0] OP_ECHO = 8'hEC;
  localparam logic [7:0] OP_ADD  = 8'hA0;
  localparam logic [7:0] OP_MUL  = 8'hA1;
  localparam logic [7:0] OP_DIV  = 8'hA2;

  localparam int HDR_BYTES = 4;

  typedef logic [15:0] pkt_len_t;

  typedef enum logic [2:0] {
    S_OP,
    S_RSVD,
    S_LEN_LO,
    S_LEN_HI,
    S_ECHO,
    S_COLLECT,
    S_EMIT,
    S_DRAIN
  } parser_state_t;

  function automatic logic is_arith(input logic [7:0] op);
    return (op == OP_ADD) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_known(input logic [7:0] op);
    return (op == OP_ECHO) || is_arith(op);
  endfunction

endpackage

// File: rtl/uart_alu_parser.sv
// Packet parser: UART byte stream -> echo bytes or 32-bit ALU operands.
// Define PARSER_TIMEOUT_EN to abort packets that stall mid-stream.
//
// state     | meaning
// S_OP      | idle, next byte is the opcode
// S_RSVD    | reserved header byte, discarded
// S_LEN_LO  | length LSB
// S_LEN_HI  | length MSB, header validated on this byte
// S_ECHO    | payload passed straight through to the echo port
// S_COLLECT | payload bytes assembled into a little-endian operand
// S_EMIT    | operand offered to the ALU, input stalled
// S_DRAIN   | payload of a rejected packet discarded
module uart_alu_parser
  import uart_alu_pkg::*;
#(
  parameter int MAX_LEN_P        = 1024,
  parameter int TIMEOUT_CYCLES_P = 100000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  op_o,
  output logic [31:0] operand_o,
  output logic        operand_valid_o,
  input  logic        operand_ready_i,
  output logic        operand_last_o,
  output logic [7:0]  echo_data_o,
  output logic        echo_valid_o,
  input  logic        echo_ready_i,
  output logic        err_o
);

  localparam pkt_len_t MAX_LEN_C = pkt_len_t'(MAX_LEN_P);
  localparam pkt_len_t HDR_LEN_C = pkt_len_t'(HDR_BYTES);

  parser_state_t state_q, state_d;
  logic [7:0]    len_lo_q;
  pkt_len_t      rem_q;
  logic [1:0]    byte_idx_q;

  logic     rx_fire;
  pkt_len_t len_w, rem_w;
  logic     len_short, hdr_err, tmo_hit;

  assign rx_fire   = rx_valid_i && rx_ready_o;
  assign len_w     = {rx_data_i, len_lo_q};
  assign rem_w     = len_w - HDR_LEN_C;
  assign len_short = len_w < HDR_LEN_C;

  always_comb begin
    hdr_err = 1'b0;
    if (len_short || (len_w > MAX_LEN_C) || !is_known(op_o))
      hdr_err = 1'b1;
    else if (is_arith(op_o) && ((rem_w == '0) || (rem_w[1:0] != 2'b00)))
      hdr_err = 1'b1;
  end

`ifdef PARSER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES_P + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD_C = TMO_W'(TIMEOUT_CYCLES_P - 1);

  logic [TMO_W-1:0] tmo_cnt_q;
  logic             tmo_run;

  assign tmo_run = (state_q != S_OP) && (state_q != S_EMIT);
  assign tmo_hit = tmo_run && !rx_fire && (tmo_cnt_q == '0);

  // Down-counter reloads on every accepted byte; terminal count means stalled.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      tmo_cnt_q <= TMO_LOAD_C;
    else if (!tmo_run || rx_fire || tmo_hit)
      tmo_cnt_q <= TMO_LOAD_C;
    else
      tmo_cnt_q <= tmo_cnt_q - 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_OP;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OP:     if (rx_fire) state_d = S_RSVD;
      S_RSVD:   if (rx_fire) state_d = S_LEN_LO;
      S_LEN_LO: if (rx_fire) state_d = S_LEN_HI;
      S_LEN_HI: begin
        if (rx_fire) begin
          if (hdr_err)
            state_d = (!len_short && (rem_w != '0)) ? S_DRAIN : S_OP;
          else if (rem_w == '0)
            state_d = S_OP;
          else if (op_o == OP_ECHO)
            state_d = S_ECHO;
          else
            state_d = S_COLLECT;
        end
      end
      S_ECHO:    if (rx_fire && (rem_q == 16'd1)) state_d = S_OP;
      S_COLLECT: if (rx_fire && (byte_idx_q == 2'd3)) state_d = S_EMIT;
      S_EMIT:    if (operand_ready_i) state_d = operand_last_o ? S_OP : S_COLLECT;
      S_DRAIN:   if (rx_fire && (rem_q == 16'd1)) state_d = S_OP;
      default:   state_d = S_OP;
    endcase
    if (tmo_hit) state_d = S_OP;
  end

  always_comb begin
    rx_ready_o   = 1'b1;
    echo_data_o  = rx_data_i;
    echo_valid_o = 1'b0;
    case (state_q)
      S_ECHO: begin
        rx_ready_o   = echo_ready_i;
        echo_valid_o = rx_valid_i;
      end
      S_EMIT:  rx_ready_o = 1'b0;
      default: rx_ready_o = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      op_o            <= '0;
      operand_o       <= '0;
      operand_valid_o <= 1'b0;
      operand_last_o  <= 1'b0;
      err_o           <= 1'b0;
      len_lo_q        <= '0;
      rem_q           <= '0;
      byte_idx_q      <= '0;
    end else begin
      err_o <= 1'b0;
      case (state_q)
        S_OP: begin
          byte_idx_q <= '0;
          if (rx_fire) op_o <= rx_data_i;
        end
        S_LEN_LO: if (rx_fire) len_lo_q <= rx_data_i;
        S_LEN_HI: begin
          if (rx_fire) begin
            err_o      <= hdr_err;
            rem_q      <= len_short ? '0 : rem_w;
            byte_idx_q <= '0;
          end
        end
        S_ECHO, S_DRAIN: if (rx_fire) rem_q <= rem_q - 16'd1;
        S_COLLECT: begin
          if (rx_fire) begin
            operand_o[{byte_idx_q, 3'b000} +: 8] <= rx_data_i;
            byte_idx_q <= byte_idx_q + 2'd1;
            rem_q      <= rem_q - 16'd1;
            if (byte_idx_q == 2'd3) begin
              operand_valid_o <= 1'b1;
              operand_last_o  <= (rem_q == 16'd1);
            end
          end
        end
        S_EMIT: begin
          if (operand_ready_i) begin
            operand_valid_o <= 1'b0;
            operand_last_o  <= 1'b0;
          end
        end
        default: ;
      endcase
      if (tmo_hit) begin
        err_o           <= 1'b1;
        operand_valid_o <= 1'b0;
        operand_last_o  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_alu_parser.sv
// Self-checking bench for uart_alu_parser: directed packets plus random traffic
// against a packet-level reference model. Timeout checks run with PARSER_TIMEOUT_EN.
module tb_uart_alu_parser;
  import uart_alu_pkg::*;

  localparam int MAXL = 1024;
  localparam int TMO  = 20;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_ready_o;
  logic [7:0]  op_o;
  logic [31:0] operand_o;
  logic        operand_valid_o;
  logic        operand_ready_i;
  logic        operand_last_o;
  logic [7:0]  echo_data_o;
  logic        echo_valid_o;
  logic        echo_ready_i;
  logic        err_o;

  always #5 clk_i = ~clk_i;

  uart_alu_parser #(.MAX_LEN_P(MAXL), .TIMEOUT_CYCLES_P(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .op_o(op_o), .operand_o(operand_o), .operand_valid_o(operand_valid_o),
    .operand_ready_i(operand_ready_i), .operand_last_o(operand_last_o),
    .echo_data_o(echo_data_o), .echo_valid_o(echo_valid_o),
    .echo_ready_i(echo_ready_i), .err_o(err_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  exp_echo[$], got_echo[$];
  logic [40:0] exp_ops[$],  got_ops[$];   // {op, last, operand}
  int          exp_err = 0, got_err = 0;
  bit          rand_rdy = 1'b0;
  logic [7:0]  pkt[$], pkt2[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial forever begin
    @(negedge clk_i);
    if (rand_rdy) begin
      echo_ready_i    = ($urandom_range(0, 9) < 7);
      operand_ready_i = ($urandom_range(0, 9) < 6);
    end
  end

  // Passive monitor: records transfers and checks operand hold while stalled.
  logic [31:0] prev_operand = '0;
  bit          prev_stall = 1'b0;
  always begin
    @(negedge clk_i); #2;
    if (rst_i) prev_stall = 1'b0;
    else begin
      if (echo_valid_o && echo_ready_i) got_echo.push_back(echo_data_o);
      if (operand_valid_o && operand_ready_i) got_ops.push_back({op_o, operand_last_o, operand_o});
      if (err_o) got_err++;
      if (prev_stall) begin
        chk("hold_valid", operand_valid_o, 1);
        chk("hold_operand", operand_o, prev_operand);
      end
      if (operand_valid_o) chk("emit_rx_blocked", rx_ready_o, 0);
      prev_stall   = operand_valid_o && !operand_ready_i;
      prev_operand = operand_o;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int guard = 0;
    @(negedge clk_i);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    #1;
    while (!rx_ready_o && guard < 2000) begin
      @(negedge clk_i); #1;
      guard++;
    end
    if (!rx_ready_o) chk("rx_accept_bound", rx_ready_o, 1);
    @(posedge clk_i); #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] p[$]);
    foreach (p[i]) send_byte(p[i]);
  endtask

  task automatic mk_pkt(input logic [7:0] op, input int len, output logic [7:0] p[$]);
    int n;
    p = {};
    p.push_back(op);
    p.push_back(8'($urandom));
    p.push_back(len[7:0]);
    p.push_back(len[15:8]);
    n = (len < 4) ? 4 : len;
    for (int i = 4; i < n; i++) p.push_back(8'($urandom));
  endtask

  // Packet-level reference: classify the whole packet, then list what must come out.
  task automatic model(input logic [7:0] p[$]);
    int len, nw;
    logic [7:0] op;
    bit known, arith;
    op    = p[0];
    len   = {p[3], p[2]};
    arith = (op == 8'hA0) || (op == 8'hA1) || (op == 8'hA2);
    known = arith || (op == 8'hEC);
    if (len < 4 || len > MAXL || !known || (arith && (len == 4 || (len - 4) % 4 != 0)))
      exp_err++;
    else if (op == 8'hEC)
      for (int i = 4; i < len; i++) exp_echo.push_back(p[i]);
    else begin
      nw = (len - 4) / 4;
      for (int w = 0; w < nw; w++)
        exp_ops.push_back({op, (w == nw - 1), p[4*w+7], p[4*w+6], p[4*w+5], p[4*w+4]});
    end
  endtask

  task automatic clear_q();
    exp_echo = {}; got_echo = {};
    exp_ops  = {}; got_ops  = {};
    exp_err  = 0;  got_err  = 0;
  endtask

  task automatic finish_pkt(input string tag);
    int g = 0;
    while (!(dut.state_q == S_OP && !operand_valid_o) && g < 5000) begin
      @(negedge clk_i); #2;
      g++;
    end
    chk({tag, "_idle"}, (dut.state_q == S_OP) && !operand_valid_o, 1);
    repeat (3) @(negedge clk_i);
    #3;
    chk({tag, "_echo_n"}, got_echo.size(), exp_echo.size());
    for (int i = 0; i < got_echo.size() && i < exp_echo.size(); i++)
      chk({tag, "_echo"}, got_echo[i], exp_echo[i]);
    chk({tag, "_ops_n"}, got_ops.size(), exp_ops.size());
    for (int i = 0; i < got_ops.size() && i < exp_ops.size(); i++)
      chk({tag, "_op"}, got_ops[i], exp_ops[i]);
    chk({tag, "_err_n"}, got_err, exp_err);
    clear_q();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_op"}, op_o, 0);
    chk({tag, "_operand"}, operand_o, 0);
    chk({tag, "_valid"}, operand_valid_o, 0);
    chk({tag, "_last"}, operand_last_o, 0);
    chk({tag, "_echo_valid"}, echo_valid_o, 0);
    chk({tag, "_err"}, err_o, 0);
    chk({tag, "_state"}, dut.state_q == S_OP, 1);
  endtask

  initial begin
    logic [31:0] v;
    int hit;
    rst_i = 1'b0;
    rx_data_i = '0; rx_valid_i = 1'b0;
    echo_ready_i = 1'b1; operand_ready_i = 1'b1;
    #1 rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    #2 chk_reset_vals("reset");
    @(negedge clk_i) rst_i = 1'b0;
    clear_q();

    // ECHO with three payload bytes
    pkt = {8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
    model(pkt); send_pkt(pkt); finish_pkt("echo3");

    // ADD with two operands
    pkt = {8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    model(pkt); send_pkt(pkt); finish_pkt("add2");

    // MUL with the ALU stalling on the first operand
    operand_ready_i = 1'b0;
    mk_pkt(8'hA1, 12, pkt);
    model(pkt);
    fork
      send_pkt(pkt);
      begin
        int g = 0;
        while (!operand_valid_o && g < 500) begin @(negedge clk_i); #2; g++; end
        chk("mul_first_valid", operand_valid_o, 1);
        v = operand_o;
        chk("mul_first_operand", v, exp_ops[0][31:0]);
        repeat (50) begin
          @(negedge clk_i); #2;
          chk("mul_stall_operand", operand_o, v);
          chk("mul_stall_rxrdy", rx_ready_o, 0);
        end
        @(negedge clk_i);
        operand_ready_i = 1'b1;
      end
    join
    finish_pkt("mul_stall");

    // Malformed ADD (rem=3) is drained, then an ECHO parses
    pkt = {8'hA0, 8'h00, 8'h07, 8'h00, 8'hEC, 8'h00, 8'h05};
    mk_pkt(8'hEC, 6, pkt2);
    model(pkt); model(pkt2);
    send_pkt(pkt); send_pkt(pkt2); finish_pkt("bad_add");

    // Unknown opcode, then short length followed directly by a valid ADD
    pkt = {8'h5F, 8'h00, 8'h04, 8'h00};
    model(pkt); send_pkt(pkt); finish_pkt("unk_op");
    pkt = {8'hEC, 8'h00, 8'h03, 8'h00};
    mk_pkt(8'hA0, 8, pkt2);
    model(pkt); model(pkt2);
    send_pkt(pkt); send_pkt(pkt2); finish_pkt("len3");

    // Length boundaries and zero-payload arithmetic
    mk_pkt(8'hEC, MAXL, pkt);     model(pkt); send_pkt(pkt); finish_pkt("len_max");
    mk_pkt(8'hEC, MAXL + 1, pkt); mk_pkt(8'hEC, 5, pkt2);
    model(pkt); model(pkt2); send_pkt(pkt); send_pkt(pkt2); finish_pkt("len_over");
    mk_pkt(8'hA0, 4, pkt);        model(pkt); send_pkt(pkt); finish_pkt("add_rem0");
    mk_pkt(8'hA2, 8, pkt);        model(pkt); send_pkt(pkt); finish_pkt("div1");
    mk_pkt(8'hEC, 4, pkt);        model(pkt); send_pkt(pkt); finish_pkt("echo_empty");

    // Reset after two operand bytes
    pkt = {8'hA0, 8'h00, 8'h08, 8'h00, 8'h11, 8'h22};
    send_pkt(pkt);
    @(negedge clk_i) rst_i = 1'b1;
    #2 chk_reset_vals("midrst");
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    clear_q();
    mk_pkt(8'hA0, 12, pkt); model(pkt); send_pkt(pkt); finish_pkt("post_rst");

    // Random traffic with random downstream readiness
    rand_rdy = 1'b1;
    for (int n = 0; n < 40; n++) begin
      int kind;
      logic [7:0] rop;
      kind = $urandom_range(0, 9);
      rop  = 8'hA0 + 8'($urandom_range(0, 2));
      if (kind <= 2)      mk_pkt(8'hEC, $urandom_range(4, 20), pkt);
      else if (kind <= 7) mk_pkt(rop, 4 + 4 * $urandom_range(1, 4), pkt);
      else if (kind == 8) mk_pkt(rop, 4 + $urandom_range(1, 15), pkt);
      else                mk_pkt(8'($urandom), $urandom_range(0, 12), pkt);
      model(pkt);
      send_pkt(pkt);
      finish_pkt("rand");
    end
    rand_rdy = 1'b0;
    @(negedge clk_i);
    echo_ready_i = 1'b1; operand_ready_i = 1'b1;

`ifdef PARSER_TIMEOUT_EN
    // Stall after a header; abort expected on the TMO-th idle cycle
    pkt = {8'hA0, 8'h00, 8'h08, 8'h00};
    send_pkt(pkt);
    hit = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk_i); #2;
      if (err_o) begin hit = k; break; end
    end
    chk("tmo_cycle", hit, TMO);
    exp_err = 1;
    finish_pkt("tmo");
    mk_pkt(8'hA0, 12, pkt); model(pkt); send_pkt(pkt); finish_pkt("tmo_recover");
`else
    hit = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
